traceback_unit: RTL and testbench
=================================

TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter WD_STATE, default 4: trellis state width (16 states).
REQ-002 SHALL have parameter WD_DEPTH, default 5: survivor page address width (32 pages).
REQ-003 SHALL have parameter WD_RAM_DATA, default 8: survivor word width from MMU.
REQ-004 SHALL have parameter TB_MERGE, default 16: traceback steps with no output.
REQ-005 SHALL have parameter TB_DECODE, default 8: traceback steps that emit decoded bits; equals WD_RAM_DATA.
REQ-006 SHALL have port CLOCK, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port Hold, input, 1: freeze all state while high.
REQ-009 SHALL have port Start, input, 1: start-traceback request, sampled in IDLE.
REQ-010 SHALL have port StartPage, input, WD_DEPTH: newest written survivor page.
REQ-011 SHALL have port StartState, input, WD_STATE: best-metric state from ACS.
REQ-012 SHALL have port DataTB, input, WD_RAM_DATA: survivor word from MMU, valid one cycle after AddressTB changes.
REQ-013 SHALL have port AddressTB, output, WD_DEPTH+1: {page, state[WD_STATE-1]} to MMU read port.
REQ-014 SHALL have port Busy, output, 1: traceback in progress.
REQ-015 SHALL have port Done, output, 1: one-cycle pulse, DecodedByte updated.
REQ-016 SHALL have port DecodedByte, output, TB_DECODE: decoded bits, bit0 oldest, bit7 newest.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, READ; all outputs registered.
REQ-018 In IDLE with Start=1 and Hold=0: load page=StartPage, state=StartState, step=0, AddressTB={StartPage, StartState[3]}, Busy=1, go WAIT.
REQ-019 Start SHALL be ignored while Busy=1 or Hold=1.
REQ-020 WAIT SHALL last exactly one cycle (RAM read latency), then go READ.
REQ-021 In READ: d = DataTB[state[2:0]]; state <= {d, state[3:1]}; page <= page-1 modulo 2^WD_DEPTH (0 wraps to 31).
REQ-022 In READ: AddressTB <= {page-1, d}; step <= step+1.
REQ-023 In READ with step >= TB_MERGE: DecodedByte[TB_DECODE-1-(step-TB_MERGE)] <= state[0] (pre-update state).
REQ-024 In READ with step = TB_MERGE+TB_DECODE-1 (23): Done=1 for one cycle, Busy=0, go IDLE; otherwise go WAIT.
REQ-025 Latency: Done SHALL assert 48 cycles after the Start-sampling edge when Hold stays low.
REQ-026 Hold=1 in WAIT/READ SHALL freeze state, step, page, AddressTB and DecodedByte; no extra cycles beyond Hold duration.
REQ-027 DecodedByte SHALL hold its value between runs; it SHALL change only during READ decode steps.
REQ-028 Done SHALL never assert without a preceding accepted Start.

Reset
REQ-029 Reset=1 SHALL have priority over Start and Hold, in every state.
REQ-030 Reset SHALL force IDLE, AddressTB=0, Busy=0, Done=0, DecodedByte=0, step=0.
REQ-031 Reset mid-traceback SHALL abort without a Done pulse; the next Start SHALL run a full 24 steps.

Structure
REQ-032 WD_STATE, WD_DEPTH, WD_RAM_DATA, TB_MERGE and TB_DECODE SHALL be defined in params.v and shared with MMU/ACS.
REQ-033 One sub-module, tbu_bitsel (survivor bit select DataTB[state[2:0]]), SHALL be instantiated; the rest is flat.

Verification
REQ-034 RAM all zero, StartPage=2, StartState=0, Start pulse -> Done at +48 cycles, DecodedByte=0x00, Busy high 48 cycles.
REQ-035 RAM all 0xFF, StartState=0 -> state sequence 0,8,12,14,15,15...; DecodedByte=0xFF.
REQ-036 StartPage=2 -> AddressTB page field 2,1,0,31,30,...,11 over 24 reads; no out-of-range address.
REQ-037 Hold high 5 cycles during step 10 -> Done at +53 cycles, DecodedByte identical to unheld run.
REQ-038 Reset at step 10 -> next cycle Busy=0, AddressTB=0, DecodedByte=0, no Done; new Start completes normally.
REQ-039 Second Start pulse at step 5 -> ignored; exactly one Done at +48 from first Start.

Source files
------------

// File: rtl/traceback_unit_pkg.sv
// Shared trellis / survivor-memory dimensions for the Viterbi traceback path.
// Imported by the traceback unit and by the MMU/ACS blocks that share these sizes.
// Also carries the traceback FSM state encoding.
package traceback_unit_pkg;

  localparam int P_WD_STATE    = 4;   // 16 trellis states
  localparam int P_WD_DEPTH    = 5;   // 32 survivor pages
  localparam int P_WD_RAM_DATA = 8;   // survivor word width
  localparam int P_TB_MERGE    = 16;  // silent traceback steps
  localparam int P_TB_DECODE   = 8;   // steps that emit a decoded bit

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2
  } tb_fsm_e;

endpackage

// File: rtl/traceback_unit_if.sv
// Control, MMU read port and result bundle of the traceback unit.
// slave: the traceback unit itself; master: the controller/MMU side driving it.
// Carries no clock; clock and reset stay plain ports on the unit.
interface traceback_unit_if
  import traceback_unit_pkg::*;
#(
  parameter int WD_STATE    = P_WD_STATE,
  parameter int WD_DEPTH    = P_WD_DEPTH,
  parameter int WD_RAM_DATA = P_WD_RAM_DATA,
  parameter int TB_DECODE   = P_TB_DECODE
);

  logic                   Hold;
  logic                   Start;
  logic [WD_DEPTH-1:0]    StartPage;
  logic [WD_STATE-1:0]    StartState;
  logic [WD_RAM_DATA-1:0] DataTB;
  logic [WD_DEPTH:0]      AddressTB;
  logic                   Busy;
  logic                   Done;
  logic [TB_DECODE-1:0]   DecodedByte;

  modport master (
    output Hold, Start, StartPage, StartState, DataTB,
    input  AddressTB, Busy, Done, DecodedByte
  );

  modport slave (
    input  Hold, Start, StartPage, StartState, DataTB,
    output AddressTB, Busy, Done, DecodedByte
  );

endinterface

// File: rtl/traceback_unit_bitsel.sv
// Survivor bit select: picks the decision bit of the current state from a survivor word.
// Purely combinational, no latency.
// The upper state bit already chose the word half through the RAM address.
module tbu_bitsel
  import traceback_unit_pkg::*;
#(
  parameter int WD_RAM_DATA = P_WD_RAM_DATA,
  parameter int WD_SEL      = $clog2(WD_RAM_DATA)
) (
  input  logic [WD_RAM_DATA-1:0] data_i,
  input  logic [WD_SEL-1:0]      sel_i,
  output logic                   bit_o
);

  // Index the survivor word with the low state bits.
  always_comb begin
    bit_o = data_i[sel_i];
  end

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: walks survivor pages backwards from the best state, emits one byte.
// Latency: Done 48 cycles after Start is accepted (24 steps x WAIT+READ), plus any Hold cycles.
// Backpressure: Hold freezes every register; Start is only looked at in IDLE with Hold low.
module traceback_unit
  import traceback_unit_pkg::*;
#(
  parameter int WD_STATE    = P_WD_STATE,
  parameter int WD_DEPTH    = P_WD_DEPTH,
  parameter int WD_RAM_DATA = P_WD_RAM_DATA,
  parameter int TB_MERGE    = P_TB_MERGE,
  parameter int TB_DECODE   = P_TB_DECODE
) (
  input logic              CLOCK,
  input logic              Reset,
  traceback_unit_if.slave  tbu
);

  localparam int WD_SEL    = $clog2(WD_RAM_DATA);
  localparam int WD_STEP   = $clog2(TB_MERGE + TB_DECODE + 1);
  localparam int WD_DIDX   = $clog2(TB_DECODE);
  localparam int LAST_STEP = TB_MERGE + TB_DECODE - 1;

  tb_fsm_e                fsm_q;
  logic [WD_STATE-1:0]    state_q, state_d;
  logic [WD_DEPTH-1:0]    page_q, page_d;
  logic [WD_STEP-1:0]     step_q;
  logic [WD_DEPTH:0]      addr_q, addr_d;
  logic                   busy_q;
  logic                   done_q;
  logic [TB_DECODE-1:0]   byte_q, byte_d;
  logic [WD_DIDX-1:0]     dec_idx;
  logic                   surv_bit;

  tbu_bitsel #(
    .WD_RAM_DATA (WD_RAM_DATA)
  ) u_bitsel (
    .data_i (tbu.DataTB),
    .sel_i  (state_q[WD_SEL-1:0]),
    .bit_o  (surv_bit)
  );

  // Next values of one READ step: shift the decision in as the new state MSB and step back a page.
  always_comb begin
    page_d  = page_q - WD_DEPTH'(1);
    state_d = {surv_bit, state_q[WD_STATE-1:1]};
    addr_d  = {page_d, surv_bit};
    // Last step writes bit 0 (oldest bit), first decode step writes the MSB.
    dec_idx = WD_DIDX'(LAST_STEP) - step_q[WD_DIDX-1:0];
    byte_d  = byte_q;
    if (step_q >= WD_STEP'(TB_MERGE)) begin
      byte_d[dec_idx] = state_q[0];
    end
  end

  // Traceback FSM with registered outputs; Reset beats Hold and Start, Hold freezes everything.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      page_q  <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!tbu.Hold) begin
        case (fsm_q)
          S_IDLE: begin
            if (tbu.Start) begin
              page_q  <= tbu.StartPage;
              state_q <= tbu.StartState;
              step_q  <= '0;
              addr_q  <= {tbu.StartPage, tbu.StartState[WD_STATE-1]};
              busy_q  <= 1'b1;
              fsm_q   <= S_WAIT;
            end
          end
          S_WAIT: begin
            // One cycle for the survivor RAM to return the word.
            fsm_q <= S_READ;
          end
          S_READ: begin
            page_q  <= page_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            step_q  <= step_q + WD_STEP'(1);
            byte_q  <= byte_d;
            if (step_q == WD_STEP'(LAST_STEP)) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              fsm_q  <= S_IDLE;
            end else begin
              fsm_q <= S_WAIT;
            end
          end
          default: begin
            fsm_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tbu.AddressTB   = addr_q;
  assign tbu.Busy        = busy_q;
  assign tbu.Done        = done_q;
  assign tbu.DecodedByte = byte_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit with a one-cycle-latency survivor RAM model.
// Each run starts a traceback and watches 70 cycles after the Start-sampling edge.
// Expected bytes come from uniform survivor words, so the decision depends on the page only.
module tb_traceback_unit;
  import traceback_unit_pkg::*;

  logic CLOCK = 1'b0;
  logic Reset = 1'b1;

  always #5 CLOCK = ~CLOCK;

  traceback_unit_if tbi ();

  traceback_unit dut (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .tbu   (tbi)
  );

  // Survivor RAM: 32 pages x 2 halves, registered read.
  logic [7:0] ram [0:63];
  always @(posedge CLOCK) tbi.DataTB <= ram[tbi.AddressTB];

  int checks = 0;
  int errors = 0;

  int         lat;
  int         busy_cnt;
  int         n_done;
  logic [5:0] addr_log [0:23];
  logic [5:0] hold_addr;
  logic [7:0] byte_d_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) ram[i] = v;
  endtask

  // Pages 1, 2 and 5 decide '1', all others '0'.
  task automatic fill_pattern();
    fill(8'h00);
    ram[{5'd1, 1'b0}] = 8'hFF; ram[{5'd1, 1'b1}] = 8'hFF;
    ram[{5'd2, 1'b0}] = 8'hFF; ram[{5'd2, 1'b1}] = 8'hFF;
    ram[{5'd5, 1'b0}] = 8'hFF; ram[{5'd5, 1'b1}] = 8'hFF;
  endtask

  task automatic run_trace(input logic [4:0] spage, input logic [3:0] sstate,
                           input int hold_at, input int hold_len,
                           input int rst_at, input int start2_at);
    int cyc;
    lat = -1; busy_cnt = 0; n_done = 0;
    @(negedge CLOCK);
    tbi.Start = 1'b1; tbi.StartPage = spage; tbi.StartState = sstate;
    @(posedge CLOCK);
    @(negedge CLOCK);
    tbi.Start = 1'b0;
    cyc = 0;
    while (cyc < 70) begin
      if (tbi.Done) begin
        n_done++;
        if (lat < 0) lat = cyc;
      end
      if (tbi.Busy) busy_cnt++;
      if (cyc % 2 == 0 && cyc < 48) addr_log[cyc / 2] = tbi.AddressTB;
      if (cyc == hold_at) hold_addr = tbi.AddressTB;
      if (cyc == hold_at + hold_len) check_val("hold_addr_frozen", 32'(tbi.AddressTB), 32'(hold_addr));
      if (cyc == rst_at + 1) begin
        check_val("rst_mid_busy", 32'(tbi.Busy), 32'd0);
        check_val("rst_mid_addr", 32'(tbi.AddressTB), 32'd0);
        check_val("rst_mid_byte", 32'(tbi.DecodedByte), 32'd0);
        check_val("rst_mid_done", 32'(tbi.Done), 32'd0);
      end
      tbi.Hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      tbi.Start = (cyc == start2_at);
      Reset     = (cyc == rst_at);
      @(posedge CLOCK);
      cyc++;
      @(negedge CLOCK);
    end
    tbi.Hold = 1'b0; tbi.Start = 1'b0; Reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_pg;
    tbi.Hold = 1'b0; tbi.Start = 1'b0; tbi.StartPage = '0; tbi.StartState = '0;
    fill(8'h00);
    Reset = 1'b1;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check_val("rst_busy", 32'(tbi.Busy), 32'd0);
    check_val("rst_done", 32'(tbi.Done), 32'd0);
    check_val("rst_addr", 32'(tbi.AddressTB), 32'd0);
    check_val("rst_byte", 32'(tbi.DecodedByte), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    // All-zero survivors, page 2: 48-cycle latency, page walk 2..0,31..11.
    run_trace(5'd2, 4'd0, -100, 0, -100, -100);
    check_val("zero_lat", 32'(lat), 32'd48);
    check_val("zero_busy", 32'(busy_cnt), 32'd48);
    check_val("zero_ndone", 32'(n_done), 32'd1);
    check_val("zero_byte", 32'(tbi.DecodedByte), 32'h00);
    for (int k = 0; k < 24; k++) begin
      exp_pg = 5'(2 - k);
      check_val($sformatf("page_%0d", k), 32'(addr_log[k][5:1]), 32'(exp_pg));
    end

    // All-ones survivors: state 0,8,12,14,15,... so address LSB goes 0,1,1,1.
    fill(8'hFF);
    run_trace(5'd2, 4'd0, -100, 0, -100, -100);
    check_val("ones_lat", 32'(lat), 32'd48);
    check_val("ones_byte", 32'(tbi.DecodedByte), 32'hFF);
    check_val("ones_addr0", 32'(addr_log[0]), 32'd4);
    check_val("ones_addr1", 32'(addr_log[1]), 32'd3);
    check_val("ones_addr2", 32'(addr_log[2]), 32'd1);
    check_val("ones_addr3", 32'(addr_log[3]), 32'd63);

    // Page pattern with Hold for 5 cycles over step 10: byte bit b = page b+1 -> 0x13.
    fill_pattern();
    run_trace(5'd20, 4'b1010, 21, 5, -100, -100);
    check_val("hold_lat", 32'(lat), 32'd53);
    check_val("hold_busy", 32'(busy_cnt), 32'd53);
    check_val("hold_byte", 32'(tbi.DecodedByte), 32'h13);
    byte_d_run = tbi.DecodedByte;

    // Reset at step 10: abort without Done, byte cleared.
    run_trace(5'd20, 4'b1010, -100, 0, 20, -100);
    check_val("rst_run_ndone", 32'(n_done), 32'd0);
    check_val("rst_run_byte_kept", 32'(tbi.DecodedByte), 32'h00);

    // Fresh start after the abort, no Hold: same byte as the held run.
    run_trace(5'd20, 4'b1010, -100, 0, -100, -100);
    check_val("pat_lat", 32'(lat), 32'd48);
    check_val("pat_addr0", 32'(addr_log[0]), 32'd41);
    check_val("pat_byte", 32'(tbi.DecodedByte), 32'h13);
    check_val("pat_vs_hold", 32'(tbi.DecodedByte), 32'(byte_d_run));

    // Second Start pulse while busy is ignored: one Done only.
    fill(8'hFF);
    run_trace(5'd7, 4'd3, -100, 0, -100, 10);
    check_val("dbl_lat", 32'(lat), 32'd48);
    check_val("dbl_ndone", 32'(n_done), 32'd1);
    check_val("dbl_byte", 32'(tbi.DecodedByte), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
